pipe_dest_track: RTL and testbench
==================================

PIPE_DEST_TRACK -- requirements
Module: pipe_dest_track

Interface
REQ-001 The block SHALL expose the following ports, with clock and reset first; reset is asynchronous and active-high (already decided).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  decode slot holds an instruction.
- id_rw  in  1  decode instruction writes the register file.
- id_dr  in  3  decode destination register.
- id_ld  in  1  decode instruction is a load.
- id_halt  in  1  decode instruction is HALT.
- id_rs, id_rt  in  3 each  decode source registers.
- id_rs_vld, id_rt_vld  in  1 each  the source is actually read.
- mem_stall  in  1  data memory busy; freeze all stages.
- flush  in  1  branch resolved taken; squash decode and X stage.
- xm_rw, xm_dr  out  1/3  EX/MEM write-enable and destination, for the forwarding unit.
- mwb_rw, mwb_dr  out  1/3  MEM/WB write-enable and destination, for the forwarding unit.
- stall  out  1  hold PC and IF/ID this cycle.
- done  out  1  HALT has retired; the pipeline is quiescent.
- lu_cnt  out  8  saturating count of load-use bubbles inserted.

Function
REQ-002 The block SHALL hold three stage registers: DX, XM and MWB; each holds {valid, rw, dr, ld, halt}.
REQ-003 xm_rw SHALL equal XM.valid & XM.rw, and mwb_rw SHALL equal MWB.valid & MWB.rw; xm_dr and mwb_dr SHALL be driven straight from the registers.
REQ-004 The load-use hazard (lu) SHALL be true when DX.valid & DX.ld & DX.rw, and DX.dr equals either id_rs with id_rs_vld=1, or id_rt with id_rt_vld=1, and id_valid=1.
REQ-005 The lu comparison SHALL treat register 0 as an ordinary register, with no special case.
REQ-006 Advance rule: when mem_stall=0, each rising edge SHALL move DX->XM and XM->MWB, and discard the old MWB.
REQ-007 DX load priority when mem_stall=0 SHALL be, highest first:
- flush: bubble into DX (valid=0).
- lu: bubble into DX.
- State is not RUN: bubble into DX.
- Otherwise: DX receives the id_* fields, with valid=id_valid.
REQ-008 When mem_stall=1, all three stage registers, the FSM, and lu_cnt SHALL hold; flush SHALL be ignored that cycle, and upstream keeps it asserted until mem_stall=0.
REQ-009 stall SHALL equal mem_stall | (lu & ~flush) | (state != RUN), as a purely combinational output with zero latency.
REQ-010 lu_cnt SHALL increment by 1 on each edge where mem_stall=0, flush=0, state=RUN and lu=1.
REQ-011 lu_cnt SHALL saturate at 255 and never wrap.
REQ-012 The FSM states SHALL be RUN, DRAIN and HALTED.
REQ-013 RUN->DRAIN SHALL occur on the edge that loads a valid HALT into DX; the HALT occupies DX that edge.
REQ-014 DRAIN->HALTED SHALL occur on the edge where MWB holds a valid HALT and mem_stall=0.
REQ-015 HALTED SHALL be left only by rst.
REQ-016 In DRAIN, instructions older than HALT SHALL continue to advance normally.
REQ-017 done SHALL be 1 only in HALTED, where all stages read as bubbles.
REQ-018 A flush in DRAIN SHALL NOT cancel the HALT; a HALT that has reached DX cannot be squashed by a younger branch.
REQ-019 lu and flush together SHALL produce a single bubble; the flush wins and lu_cnt does not increment.

Reset
REQ-020 While rst=1, asynchronously: every stage valid=0, all stage fields 0, FSM=RUN, lu_cnt=0.
REQ-021 The outputs during reset SHALL be: xm_rw=0, mwb_rw=0, xm_dr=0, mwb_dr=0, stall=mem_stall, done=0.
REQ-022 Reset asserted mid-DRAIN or mid-mem_stall SHALL take effect immediately and discard all in-flight state.
REQ-023 The first edge after rst falls SHALL be treated as a normal RUN-state cycle.

Verification
REQ-024 Back-to-back writers: ADD r3 then ADD r4, with no stalls -> after 2 edges xm_dr=4, mwb_dr=3, both rw=1; after 3 edges mwb_dr=4, xm_rw=0.
REQ-025 Load-use: LD r2 in DX, decode reads rs=r2 with rs_vld=1 -> stall=1 and lu_cnt=1; next edge DX is a bubble and XM holds LD with xm_dr=2; stall then drops.
REQ-026 Non-read source: same as REQ-025 but rs_vld=0 and rt differs -> stall=0 and lu_cnt stays 0.
REQ-027 mem_stall held 3 cycles with XM holding r5 -> xm_dr=5 for all 3 cycles, stall=1, then the pipeline resumes; flush pulses during mem_stall have no effect.
REQ-028 HALT then ADD r1 behind it -> ADD never enters DX and stall=1 from DRAIN on; done=1 exactly 3 edges after HALT enters DX; rst then returns FSM=RUN and done=0.
REQ-029 lu_cnt saturation: 300 consecutive load-use cycles -> lu_cnt=255 and holds; a simultaneous flush+lu cycle leaves lu_cnt unchanged.

Source files
------------

// File: rtl/pipe_dest_track_if.sv
// rtl/pipe_dest_track_if.sv - decode/control inputs and forwarding/stall outputs of pipe_dest_track
// The master drives decode and control; the slave is the tracker.
interface pipe_dest_track_if;
   logic       id_valid;
   logic       id_rw;
   logic [2:0] id_dr;
   logic       id_ld;
   logic       id_halt;
   logic [2:0] id_rs;
   logic [2:0] id_rt;
   logic       id_rs_vld;
   logic       id_rt_vld;
   logic       mem_stall;
   logic       flush;
   logic       xm_rw;
   logic [2:0] xm_dr;
   logic       mwb_rw;
   logic [2:0] mwb_dr;
   logic       stall;
   logic       done;
   logic [7:0] lu_cnt;

   modport master (
      output id_valid, id_rw, id_dr, id_ld, id_halt, id_rs, id_rt, id_rs_vld, id_rt_vld,
      output mem_stall, flush,
      input  xm_rw, xm_dr, mwb_rw, mwb_dr, stall, done, lu_cnt
   );

   modport slave (
      input  id_valid, id_rw, id_dr, id_ld, id_halt, id_rs, id_rt, id_rs_vld, id_rt_vld,
      input  mem_stall, flush,
      output xm_rw, xm_dr, mwb_rw, mwb_dr, stall, done, lu_cnt
   );
endinterface

// File: rtl/pipe_dest_track.sv
// rtl/pipe_dest_track.sv - destination tracking, load-use detection and HALT drain for a 3-stage back end
// Stage registers DX/XM/MWB carry {valid, rw, dr, ld, halt}; a small FSM drains the pipe behind HALT.
module pipe_dest_track (
   input  logic             clk,
   input  logic             rst,
   pipe_dest_track_if.slave trk_if
);

   typedef struct packed {
      logic       valid;
      logic       rw;
      logic [2:0] dr;
      logic       ld;
      logic       halt;
   } stage_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   stage_t     dx_q, dx_d, xm_q, xm_d, mwb_q, mwb_d;
   stage_t     id_stage;
   state_t     state_q, state_d;
   logic [7:0] lu_cnt_q, lu_cnt_d;
   logic       rs_hit, rt_hit, lu;

   assign id_stage = '{valid: trk_if.id_valid, rw: trk_if.id_rw, dr: trk_if.id_dr,
                       ld: trk_if.id_ld, halt: trk_if.id_halt};

   // r0 is compared like any other register
   assign rs_hit = trk_if.id_rs_vld && (trk_if.id_rs == dx_q.dr);
   assign rt_hit = trk_if.id_rt_vld && (trk_if.id_rt == dx_q.dr);
   assign lu     = dx_q.valid && dx_q.ld && dx_q.rw && trk_if.id_valid && (rs_hit || rt_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dx_q     <= '0;
         xm_q     <= '0;
         mwb_q    <= '0;
         state_q  <= RUN;
         lu_cnt_q <= '0;
      end else begin
         dx_q     <= dx_d;
         xm_q     <= xm_d;
         mwb_q    <= mwb_d;
         state_q  <= state_d;
         lu_cnt_q <= lu_cnt_d;
      end
   end

   always_comb begin
      dx_d     = dx_q;
      xm_d     = xm_q;
      mwb_d    = mwb_q;
      state_d  = state_q;
      lu_cnt_d = lu_cnt_q;
      if (!trk_if.mem_stall) begin
         mwb_d = xm_q;
         xm_d  = dx_q;
         // a HALT already in DX moves on to XM here, so a flush cannot cancel it
         if (trk_if.flush || lu || (state_q != RUN))
            dx_d = '0;
         else
            dx_d = id_stage;
         if (!trk_if.flush && lu && (state_q == RUN) && (lu_cnt_q != 8'hFF))
            lu_cnt_d = lu_cnt_q + 8'd1;
         case (state_q)
            RUN:     if (!trk_if.flush && !lu && id_stage.valid && id_stage.halt) state_d = DRAIN;
            DRAIN:   if (mwb_q.valid && mwb_q.halt) state_d = HALTED;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      trk_if.xm_rw  = xm_q.valid & xm_q.rw;
      trk_if.xm_dr  = xm_q.dr;
      trk_if.mwb_rw = mwb_q.valid & mwb_q.rw;
      trk_if.mwb_dr = mwb_q.dr;
      trk_if.stall  = trk_if.mem_stall | (lu & ~trk_if.flush) | (state_q != RUN);
      trk_if.done   = (state_q == HALTED);
      trk_if.lu_cnt = lu_cnt_q;
   end

endmodule

// File: tb/tb_pipe_dest_track.sv
// tb/tb_pipe_dest_track.sv - directed self-checking bench for pipe_dest_track
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pipe_dest_track;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pipe_dest_track_if bus ();

   pipe_dest_track dut (
      .clk    (clk),
      .rst    (rst),
      .trk_if (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic rw, input logic [2:0] dr, input logic ld,
                         input logic halt, input logic [2:0] rs, input logic rsv,
                         input logic [2:0] rt, input logic rtv);
      bus.id_valid  = v;
      bus.id_rw     = rw;
      bus.id_dr     = dr;
      bus.id_ld     = ld;
      bus.id_halt   = halt;
      bus.id_rs     = rs;
      bus.id_rs_vld = rsv;
      bus.id_rt     = rt;
      bus.id_rt_vld = rtv;
   endtask

   task automatic idle();
      set_id(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      bus.mem_stall = 1'b0;
      bus.flush     = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_id(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      bus.mem_stall = 1'b1;
      bus.flush     = 1'b0;
      #2;
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL reset_xm_rw: got %b expected 0", bus.xm_rw); end
      checks++; if (bus.mwb_rw !== 1'b0) begin errors++; $display("FAIL reset_mwb_rw: got %b expected 0", bus.mwb_rw); end
      checks++; if (bus.xm_dr !== 3'd0)  begin errors++; $display("FAIL reset_xm_dr: got %0d expected 0", bus.xm_dr); end
      checks++; if (bus.mwb_dr !== 3'd0) begin errors++; $display("FAIL reset_mwb_dr: got %0d expected 0", bus.mwb_dr); end
      checks++; if (bus.done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.lu_cnt !== 8'd0) begin errors++; $display("FAIL reset_lu_cnt: got %0d expected 0", bus.lu_cnt); end
      checks++; if (bus.stall !== 1'b1)  begin errors++; $display("FAIL reset_stall_ms1: got %b expected 1", bus.stall); end
      bus.mem_stall = 1'b0;
      step();
      step();
      checks++; if (bus.stall !== 1'b0)  begin errors++; $display("FAIL reset_stall_ms0: got %b expected 0", bus.stall); end
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL reset_held_xm_rw: got %b expected 0", bus.xm_rw); end
      rst = 1'b0;
      idle();
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_id(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      set_id(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b expected 0", bus.stall); end
      step();
      idle();
      step();
      checks++; if (bus.xm_dr !== 3'd4)  begin errors++; $display("FAIL b2b_e2_xm_dr: got %0d expected 4", bus.xm_dr); end
      checks++; if (bus.mwb_dr !== 3'd3) begin errors++; $display("FAIL b2b_e2_mwb_dr: got %0d expected 3", bus.mwb_dr); end
      checks++; if (bus.xm_rw !== 1'b1)  begin errors++; $display("FAIL b2b_e2_xm_rw: got %b expected 1", bus.xm_rw); end
      checks++; if (bus.mwb_rw !== 1'b1) begin errors++; $display("FAIL b2b_e2_mwb_rw: got %b expected 1", bus.mwb_rw); end
      step();
      checks++; if (bus.mwb_dr !== 3'd4) begin errors++; $display("FAIL b2b_e3_mwb_dr: got %0d expected 4", bus.mwb_dr); end
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL b2b_e3_xm_rw: got %b expected 0", bus.xm_rw); end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      set_id(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd2, 1'b1, 3'd7, 1'b0);
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", bus.stall); end
      step();
      checks++; if (bus.lu_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt_one: got %0d expected 1", bus.lu_cnt); end
      checks++; if (bus.xm_dr !== 3'd2)  begin errors++; $display("FAIL lu_xm_dr: got %0d expected 2", bus.xm_dr); end
      checks++; if (bus.xm_rw !== 1'b1)  begin errors++; $display("FAIL lu_xm_rw: got %b expected 1", bus.xm_rw); end
      checks++; if (bus.stall !== 1'b0)  begin errors++; $display("FAIL lu_stall_drop: got %b expected 0", bus.stall); end
      step();
      idle();
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL lu_bubble_xm_rw: got %b expected 0", bus.xm_rw); end
      checks++; if (bus.mwb_dr !== 3'd2) begin errors++; $display("FAIL lu_mwb_dr: got %0d expected 2", bus.mwb_dr); end
      checks++; if (bus.lu_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt_hold: got %0d expected 1", bus.lu_cnt); end
   endtask

   task automatic test_non_read();
      do_reset();
      set_id(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      set_id(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd2, 1'b0, 3'd3, 1'b1);
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL nr_stall: got %b expected 0", bus.stall); end
      step();
      checks++; if (bus.lu_cnt !== 8'd0) begin errors++; $display("FAIL nr_lu_cnt: got %0d expected 0", bus.lu_cnt); end
      // r0 load followed by a reader of r0 still stalls
      do_reset();
      set_id(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      set_id(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd4, 1'b0, 3'd0, 1'b1);
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL r0_stall: got %b expected 1", bus.stall); end
      step();
      checks++; if (bus.lu_cnt !== 8'd1) begin errors++; $display("FAIL r0_lu_cnt: got %0d expected 1", bus.lu_cnt); end
      idle();
   endtask

   task automatic test_mem_stall();
      do_reset();
      set_id(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      idle();
      step();
      bus.mem_stall = 1'b1;
      set_id(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.flush = (i != 1);
         #1;
         checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ms_stall_%0d: got %b expected 1", i, bus.stall); end
         step();
         checks++; if (bus.xm_dr !== 3'd5) begin errors++; $display("FAIL ms_xm_dr_%0d: got %0d expected 5", i, bus.xm_dr); end
         checks++; if (bus.xm_rw !== 1'b1) begin errors++; $display("FAIL ms_xm_rw_%0d: got %b expected 1", i, bus.xm_rw); end
      end
      bus.mem_stall = 1'b0;
      bus.flush     = 1'b0;
      idle();
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ms_release_stall: got %b expected 0", bus.stall); end
      step();
      checks++; if (bus.mwb_dr !== 3'd5) begin errors++; $display("FAIL ms_resume_mwb_dr: got %0d expected 5", bus.mwb_dr); end
      checks++; if (bus.mwb_rw !== 1'b1) begin errors++; $display("FAIL ms_resume_mwb_rw: got %b expected 1", bus.mwb_rw); end
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL ms_resume_xm_rw: got %b expected 0", bus.xm_rw); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_id(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      idle();
      step();
      bus.mem_stall = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      checks++; if (bus.xm_rw !== 1'b0) begin errors++; $display("FAIL ar_xm_rw: got %b expected 0", bus.xm_rw); end
      checks++; if (bus.xm_dr !== 3'd0) begin errors++; $display("FAIL ar_xm_dr: got %0d expected 0", bus.xm_dr); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ar_stall: got %b expected 1", bus.stall); end
      #1;
      rst = 1'b0;
      bus.mem_stall = 1'b0;
      set_id(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      idle();
      step();
      checks++; if (bus.xm_dr !== 3'd7) begin errors++; $display("FAIL ar_first_edge_xm_dr: got %0d expected 7", bus.xm_dr); end
      checks++; if (bus.xm_rw !== 1'b1) begin errors++; $display("FAIL ar_first_edge_xm_rw: got %b expected 1", bus.xm_rw); end
   endtask

   task automatic test_halt();
      do_reset();
      set_id(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      step();
      set_id(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL halt_drain_stall: got %b expected 1", bus.stall); end
      checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL halt_e0_done: got %b expected 0", bus.done); end
      step();
      bus.flush = 1'b0;
      checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL halt_e1_done: got %b expected 0", bus.done); end
      step();
      checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL halt_e2_done: got %b expected 0", bus.done); end
      checks++; if (bus.xm_rw !== 1'b0) begin errors++; $display("FAIL halt_e2_xm_rw: got %b expected 0", bus.xm_rw); end
      step();
      checks++; if (bus.done !== 1'b1)  begin errors++; $display("FAIL halt_e3_done: got %b expected 1", bus.done); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL halt_e3_stall: got %b expected 1", bus.stall); end
      step();
      step();
      checks++; if (bus.done !== 1'b1)   begin errors++; $display("FAIL halt_hold_done: got %b expected 1", bus.done); end
      checks++; if (bus.xm_rw !== 1'b0)  begin errors++; $display("FAIL halt_hold_xm_rw: got %b expected 0", bus.xm_rw); end
      checks++; if (bus.mwb_rw !== 1'b0) begin errors++; $display("FAIL halt_hold_mwb_rw: got %b expected 0", bus.mwb_rw); end
      checks++; if (bus.mwb_dr !== 3'd0) begin errors++; $display("FAIL halt_hold_mwb_dr: got %0d expected 0", bus.mwb_dr); end
      rst = 1'b1;
      #1;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL halt_rst_done: got %b expected 0", bus.done); end
      rst = 1'b0;
      idle();
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL halt_rst_stall: got %b expected 0", bus.stall); end
   endtask

   task automatic test_saturation();
      do_reset();
      // a load of r2 that reads r2: every second edge is a load-use bubble
      set_id(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      checks++; if (bus.lu_cnt !== 8'd10) begin errors++; $display("FAIL sat_cnt_10: got %0d expected 10", bus.lu_cnt); end
      step();
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sat_flush_lu_stall: got %b expected 0", bus.stall); end
      step();
      bus.flush = 1'b0;
      checks++; if (bus.lu_cnt !== 8'd10) begin errors++; $display("FAIL sat_flush_lu_cnt: got %0d expected 10", bus.lu_cnt); end
      step();
      step();
      checks++; if (bus.lu_cnt !== 8'd11) begin errors++; $display("FAIL sat_cnt_11: got %0d expected 11", bus.lu_cnt); end
      for (int i = 0; i < 600; i++) step();
      checks++; if (bus.lu_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_255: got %0d expected 255", bus.lu_cnt); end
      for (int i = 0; i < 10; i++) step();
      checks++; if (bus.lu_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt_hold: got %0d expected 255", bus.lu_cnt); end
      idle();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load_use();
      test_non_read();
      test_mem_stall();
      test_async_reset();
      test_halt();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
